// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
// Bundles the read, write, allocate and clear signals of the scoreboarded
// register file.
//
//   rd_addr      [NRD][AW]     read port addresses
//   rd_data      [NRD][WIDTH]  read data, combinational with write bypass
//   rd_ready     [NRD]         1 = addressed register has no pending writer
//   wr_en        [NWR]         write enables
//   wr_addr      [NWR][AW]     write addresses
//   wr_data      [NWR][WIDTH]  write data
//   alloc_en                   mark alloc_addr busy
//   alloc_addr   [AW]          register to mark busy
//   clr_req                    start a full-array clear sweep
//   sweep_active               clear sweep in progress
//
// master: the client driving requests; slave: the register file.
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) ();
  localparam int AW = $clog2(DEPTH);

  logic [NRD-1:0][AW-1:0]    rd_addr;
  logic [NRD-1:0][WIDTH-1:0] rd_data;
  logic [NRD-1:0]            rd_ready;
  logic [NWR-1:0]            wr_en;
  logic [NWR-1:0][AW-1:0]    wr_addr;
  logic [NWR-1:0][WIDTH-1:0] wr_data;
  logic                      alloc_en;
  logic [AW-1:0]             alloc_addr;
  logic                      clr_req;
  logic                      sweep_active;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, clr_req,
    input  rd_data, rd_ready, sweep_active
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, clr_req,
    output rd_data, rd_ready, sweep_active
  );
endinterface

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Multi-ported register file with a per-register busy (scoreboard) bit and
// a hardware clear sweep.
//
// Ports:
//   clk    single clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset; starts a clear sweep
//   bus    regfile_sb_if.slave (read/write/alloc/clear signals)
//
// Behaviour summary:
//   - CLEAR state: one register per cycle is zeroed and its busy bit cleared,
//     walking index 0..DEPTH-1. All requests are ignored and every read port
//     returns data 0 / ready 0.
//   - IDLE state: writes land at the next edge (highest port wins on a
//     conflict), reads bypass same-cycle writes, alloc sets busy, a write
//     clears busy, alloc beats a same-cycle write for the busy bit.
//   - With ZERO_R0 set, register 0 always reads 0 and is never busy.
//   - The data array itself is not reset; the sweep is what makes it known.
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [AW-1:0]             cnt_q;
  logic [AW-1:0]             cnt_d;
  logic [DEPTH-1:0]          busy_q;
  logic [DEPTH-1:0]          busy_d;
  logic [WIDTH-1:0]          mem [DEPTH];
  logic                      sweeping;
  logic [NRD-1:0][WIDTH-1:0] rd_data_c;
  logic [NRD-1:0]            rd_ready_c;

  assign sweeping = (state_q == CLEAR);

  // -------------------------------------------------------------------------
  // Control state: FSM, sweep counter and busy bits (asynchronously reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Busy update: writes clear first, then alloc sets, so alloc wins when both
  // hit the same register in one cycle.
  always_comb begin
    busy_d = busy_q;
    if (sweeping) begin
      busy_d[cnt_q] = 1'b0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (bus.wr_en[i]) begin
          busy_d[bus.wr_addr[i]] = 1'b0;
        end
      end
      if (bus.alloc_en) begin
        busy_d[bus.alloc_addr] = 1'b1;
      end
    end
    if (ZERO_R0 != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Data array (no reset). Ports are applied in ascending order so the
  // highest-indexed enabled port owns the final value on an address clash.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sweeping) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (bus.wr_en[i]) begin
          mem[bus.wr_addr[i]] <= bus.wr_data[i];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read ports: stored value, overridden by same-cycle writes in port order.
  // Ready comes straight from the registered busy bits, never bypassed.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_data_c  = '0;
    rd_ready_c = '0;
    for (int j = 0; j < NRD; j++) begin
      rd_data_c[j]  = mem[bus.rd_addr[j]];
      rd_ready_c[j] = ~busy_q[bus.rd_addr[j]];
      for (int i = 0; i < NWR; i++) begin
        if (bus.wr_en[i] && (bus.wr_addr[i] == bus.rd_addr[j])) begin
          rd_data_c[j] = bus.wr_data[i];
        end
      end
      if ((ZERO_R0 != 0) && (bus.rd_addr[j] == '0)) begin
        rd_data_c[j]  = '0;
        rd_ready_c[j] = 1'b1;
      end
      // During the sweep nothing in the array is trustworthy yet.
      if (sweeping) begin
        rd_data_c[j]  = '0;
        rd_ready_c[j] = 1'b0;
      end
    end
  end

  assign bus.rd_data      = rd_data_c;
  assign bus.rd_ready     = rd_ready_c;
  assign bus.sweep_active = sweeping;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
- REQ-001: Parameter WIDTH, default 32, data width in bits.
- REQ-002: Parameter DEPTH, default 32, number of registers (power of two, >= 4); AW = $clog2(DEPTH).
- REQ-003: Parameter NRD, default 2, number of read ports.
- REQ-004: Parameter NWR, default 2, number of write ports.
- REQ-005: Parameter ZERO_R0, default 1; when 1, register 0 reads 0, ignores writes and is never busy.
- REQ-006: clk  input  1  single clock, all state updates on rising edge.
- REQ-007: rst_n  input  1  reset, asynchronous and active-low.
- REQ-008: rd_addr  input  NRD x AW  read port addresses.
- REQ-009: rd_data  output  NRD x WIDTH  read data, combinational.
- REQ-010: rd_ready  output  NRD  1 = addressed register not busy.
- REQ-011: wr_en  input  NWR  write enables.
- REQ-012: wr_addr  input  NWR x AW  write addresses.
- REQ-013: wr_data  input  NWR x WIDTH  write data.
- REQ-014: alloc_en  input  1  mark alloc_addr busy (pending writer).
- REQ-015: alloc_addr  input  AW  register to mark busy.
- REQ-016: clr_req  input  1  request full-array clear sweep.
- REQ-017: sweep_active  output  1  clear sweep in progress; all other requests ignored.

Function
- REQ-018: FSM states: CLEAR, IDLE; CLEAR -> IDLE after index DEPTH-1 written; IDLE -> CLEAR on clr_req.
- REQ-019: In CLEAR, one register per cycle at sweep counter index is written 0 and its busy bit cleared; counter increments by 1, resets to 0 on entry.
- REQ-020: Sweep length is exactly DEPTH cycles; sweep_active = 1 for exactly those cycles.
- REQ-021: In CLEAR, wr_en, alloc_en and clr_req are ignored; rd_data = 0 and rd_ready = 0 on all ports.
- REQ-022: In IDLE, each wr_en[i] writes wr_data[i] to wr_addr[i] at the next edge.
- REQ-023: Same-address write conflict: highest-indexed enabled port wins.
- REQ-024: Read bypass: if any enabled write port targets rd_addr[j] in the same cycle, rd_data[j] = winning wr_data (REQ-023 priority), else stored value.
- REQ-025: Register 0 with ZERO_R0 = 1: rd_data = 0 regardless of bypass, rd_ready = 1.
- REQ-026: alloc_en in IDLE sets busy[alloc_addr] at the next edge.
- REQ-027: An enabled write clears busy[wr_addr] at the next edge.
- REQ-028: alloc and write to same address in same cycle: busy ends set (alloc wins); data still written.
- REQ-029: rd_ready[j] = !busy[rd_addr[j]] from registered state; no bypass of busy bits.
- REQ-030: Storage array has no reset; only busy bits, FSM state and sweep counter are reset.

Reset
- REQ-031: rst_n low asynchronously clears all busy bits, sets sweep counter 0, forces state CLEAR; sweep_active = 1 while in reset.
- REQ-032: After rst_n deasserts, a full DEPTH-cycle sweep runs before any write or alloc is accepted.
- REQ-033: rst_n asserted mid-sweep restarts the sweep from index 0.

Verification
- REQ-034: Release reset, defaults -> sweep_active high exactly 32 cycles, then all 32 registers read 0, rd_ready all 1.
- REQ-035: IDLE, wr port0 r5=0xAAAA0000 and port1 r5=0x5555FFFF same cycle, rd_addr[0]=5 -> rd_data 0x5555FFFF same cycle and after edge.
- REQ-036: alloc r7, next cycle rd_addr[1]=7 -> rd_ready[1]=0; write r7=0x1234 -> rd_ready[1]=1 next cycle, rd_data 0x1234.
- REQ-037: alloc r3 and write r3=0x99 same cycle -> rd_ready 0 for r3, data 0x99.
- REQ-038: write r0=0xFFFFFFFF, alloc r0 -> r0 reads 0, rd_ready 1.
- REQ-039: clr_req then write r9 during sweep, rst_n pulse at sweep cycle 10 -> write ignored, sweep restarts, 32 further cycles, r9 reads 0.
